pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program-counter register and sequences the shared pc adder (op 0=hold, 1=+1, 2=+disp, 3=-3).
//  Accepts one PC command per handshake from the decoder: increment, branch, jump or MVN/MVP block move.
//  For a block move, rewinds PC by 3 after each completed byte move until the count is exhausted.
//  Sits between the instruction decoder, the bus/move unit and the pc adder in the bc6502 core.
// PARAMETERS
//  ABW       24          address bus width; PC and displacement width
//  RESET_PC  24'h00FFFC  PC value loaded on reset
// PORTS
//  clk        in   1     core clock; all state changes on rising edge
//  reset      in   1     synchronous, active-high reset
//  rdy        in   1     global ready; 0 freezes all state (no accept, no update)
//  cmd_valid  in   1     command present
//  cmd        in   3     0=NOP 1=INC 2=BRANCH 3=JUMP 4=BLKMV (5-7 treated as NOP)
//  cmd_ready  out  1     command accepted when cmd_valid & cmd_ready
//  disp       in   ABW   signed branch displacement (sign-extended by decoder)
//  jump_addr  in   ABW   jump target for cmd 3
//  bm_count   in   16    block-move count (moves bm_count+1 bytes), sampled on BLKMV accept
//  mv_done    in   1     one-cycle pulse: bus unit finished one byte move
//  add_op     out  2     op to pc adder (combinational from state/cmd)
//  add_disp   out  ABW   disp to pc adder (disp for BRANCH, else 0)
//  add_o      in   ABW   pc adder result (combinational from pc, add_op, add_disp)
//  pc         out  ABW   current program counter (registered)
//  bm_busy    out  1     block move in progress
//  bm_done    out  1     one-cycle pulse when block move completes
//  page_cross out  1     one-cycle pulse on branch crossing a page (only with PCS_PAGE_CROSS_EN)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, count=0, bm_busy=0, bm_done=0, page_cross=0, cmd_ready=0 during reset.
//  States: IDLE, BM_WAIT, PENALTY (PENALTY exists only with the macro defined).
//  cmd_ready = rdy & (state==IDLE). If rdy=0, no register changes, pulses deasserted.
//  IDLE, accept: INC -> pc<=add_o with add_op=1; BRANCH -> add_op=2, pc<=add_o; JUMP -> pc<=jump_addr.
//   NOP or no accept -> add_op=0, pc held. New pc visible the cycle after accept (latency 1).
//  BLKMV accept: count<=bm_count, pc held, go BM_WAIT, bm_busy=1 from next cycle.
//  BM_WAIT: add_op=0 until mv_done&rdy; then if count!=0: count<=count-1, add_op=3, pc<=add_o, stay.
//   If count==0: pc held, count<=16'hFFFF, bm_done pulse, go IDLE (bm_busy=0 next cycle).
//  mv_done outside BM_WAIT is ignored. cmd_valid during BM_WAIT is not accepted.
//  Arithmetic modulo 2^ABW: pc wraps FFFFFF+1 -> 000000, 000001-3 -> FFFFFE; no flag.
//  Reset mid-block-move aborts: state IDLE, pc=RESET_PC, no bm_done pulse.
//  add_op is the only adder op source; the unit never updates pc from add_o when add_op=0.
// CONFIGURATION
//  PCS_PAGE_CROSS_EN defined: on accepted BRANCH where add_o[15:8]!=pc[15:8], page_cross
//   pulses the next cycle and state enters PENALTY for 1 cycle (cmd_ready=0), then IDLE.
//   pc update timing is unchanged.
//  Undefined: page_cross tied 0, no PENALTY state, branches take 1 cycle like INC.
// TESTING
//  Reset -> pc=00FFFC, bm_busy=0, cmd_ready=0 while reset=1 and 1 after release with rdy=1.
//  pc=001000, INC x3 back-to-back -> pc 001001,001002,001003 on successive cycles.
//  pc=0010F0, BRANCH disp=+0x20 -> pc=001110; with macro page_cross=1 and cmd_ready low 1 cycle.
//  pc=002003, BLKMV bm_count=2, 3 mv_done pulses -> pc 002000,001FFD, then held; bm_done after 3rd.
//  pc=FFFFFF INC -> 000000; pc=000001, BLKMV count=1, mv_done -> pc=FFFFFE.
//  rdy=0 with cmd_valid INC held 4 cycles -> pc unchanged; reset during BM_WAIT -> IDLE, pc=00FFFC.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Decoder-to-sequencer command channel: one PC command per valid/ready handshake.
interface pc_sequencer_if #(
  parameter int unsigned ABW = 24
);
  logic           cmd_valid;
  logic [2:0]     cmd;
  logic           cmd_ready;
  logic [ABW-1:0] disp;
  logic [ABW-1:0] jump_addr;
  logic [15:0]    bm_count;

  modport master (
    output cmd_valid, cmd, disp, jump_addr, bm_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd, disp, jump_addr, bm_count,
    output cmd_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner and pc-adder op sequencer, including MVN/MVP block-move rewind.
// Optional PCS_PAGE_CROSS_EN adds a one-cycle branch page-cross penalty and page_cross pulse.
module pc_sequencer #(
  parameter int unsigned    ABW      = 24,
  parameter logic [ABW-1:0] RESET_PC = 24'h00FFFC
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rdy,
  pc_sequencer_if.slave  cmd_bus,
  input  logic           mv_done,
  output logic [1:0]     add_op,
  output logic [ABW-1:0] add_disp,
  input  logic [ABW-1:0] add_o,
  output logic [ABW-1:0] pc,
  output logic           bm_busy,
  output logic           bm_done,
  output logic           page_cross
);

  localparam int unsigned CW = 16;

  localparam logic [2:0] CMD_INC    = 3'd1;
  localparam logic [2:0] CMD_BRANCH = 3'd2;
  localparam logic [2:0] CMD_JUMP   = 3'd3;
  localparam logic [2:0] CMD_BLKMV  = 3'd4;

  localparam logic [1:0] OP_HOLD   = 2'd0;
  localparam logic [1:0] OP_INC    = 2'd1;
  localparam logic [1:0] OP_DISP   = 2'd2;
  localparam logic [1:0] OP_REWIND = 2'd3;

`ifdef PCS_PAGE_CROSS_EN
  typedef enum logic [1:0] {IDLE, BM_WAIT, PENALTY} state_e;
`else
  typedef enum logic [0:0] {IDLE, BM_WAIT} state_e;
`endif

  state_e          state_q, state_d;
  logic [ABW-1:0]  pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            bm_done_q, bm_done_d;
  logic            page_cross_q, page_cross_d;
  logic            cmd_ready_c;
  logic            accept_c;

  assign cmd_ready_c       = rdy & ~reset & (state_q == IDLE);
  assign accept_c          = cmd_bus.cmd_valid & cmd_ready_c;
  assign cmd_bus.cmd_ready = cmd_ready_c;

  // State and datapath registers; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      count_q      <= '0;
      bm_done_q    <= 1'b0;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      bm_done_q    <= bm_done_d;
      page_cross_q <= page_cross_d;
    end
  end

  // Next-state, adder op selection and pc update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    bm_done_d    = 1'b0;
    page_cross_d = 1'b0;
    add_op       = OP_HOLD;
    add_disp     = '0;

    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            case (cmd_bus.cmd)
              CMD_INC: begin
                add_op = OP_INC;
                pc_d   = add_o;
              end
              CMD_BRANCH: begin
                add_op   = OP_DISP;
                add_disp = cmd_bus.disp;
                pc_d     = add_o;
`ifdef PCS_PAGE_CROSS_EN
                if (add_o[15:8] != pc_q[15:8]) begin
                  page_cross_d = 1'b1;
                  state_d      = PENALTY;
                end
`endif
              end
              CMD_JUMP:  pc_d = cmd_bus.jump_addr;
              CMD_BLKMV: begin
                count_d = cmd_bus.bm_count;
                state_d = BM_WAIT;
              end
              default: ;
            endcase
          end
        end
        BM_WAIT: begin
          if (mv_done) begin
            if (count_q != '0) begin
              count_d = count_q - CW'(1);
              add_op  = OP_REWIND;
              pc_d    = add_o;
            end else begin
              count_d   = '1;
              bm_done_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
`ifdef PCS_PAGE_CROSS_EN
        PENALTY: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign pc      = pc_q;
  assign bm_busy = (state_q == BM_WAIT);
  assign bm_done = bm_done_q;
`ifdef PCS_PAGE_CROSS_EN
  assign page_cross = page_cross_q;
`else
  assign page_cross = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural pc adder.
module tb_pc_sequencer;
  localparam int unsigned ABW = 24;

  logic           clk = 1'b0;
  logic           reset;
  logic           rdy;
  logic           mv_done;
  logic [1:0]     add_op;
  logic [ABW-1:0] add_disp;
  logic [ABW-1:0] add_o;
  logic [ABW-1:0] pc;
  logic           bm_busy;
  logic           bm_done;
  logic           page_cross;

  int errors = 0;
  int checks = 0;

  pc_sequencer_if #(.ABW(ABW)) bus ();

  pc_sequencer #(.ABW(ABW), .RESET_PC(24'h00FFFC)) dut (
    .clk        (clk),
    .reset      (reset),
    .rdy        (rdy),
    .cmd_bus    (bus),
    .mv_done    (mv_done),
    .add_op     (add_op),
    .add_disp   (add_disp),
    .add_o      (add_o),
    .pc         (pc),
    .bm_busy    (bm_busy),
    .bm_done    (bm_done),
    .page_cross (page_cross)
  );

  always #5 clk = ~clk;

  // Shared pc adder as it exists in the core.
  always_comb begin
    case (add_op)
      2'd1:    add_o = pc + 24'd1;
      2'd2:    add_o = pc + add_disp;
      2'd3:    add_o = pc - 24'd3;
      default: add_o = pc;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
  endtask

  initial begin
    reset         = 1'b1;
    rdy           = 1'b1;
    mv_done       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    bus.disp      = '0;
    bus.jump_addr = '0;
    bus.bm_count  = '0;

    // Reset state
    tick(); tick();
    check("rst_pc", 32'(pc), 32'h00FFFC);
    check("rst_busy", 32'(bm_busy), 0);
    check("rst_done", 32'(bm_done), 0);
    check("rst_pcross", 32'(page_cross), 0);
    check("rst_ready", 32'(bus.cmd_ready), 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.cmd_ready), 1);

    // INC x3 back-to-back
    bus.jump_addr = 24'h001000;
    issue(3'd3);
    check("jump_pc", 32'(pc), 32'h001000);
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd1;
    #1;
    check("inc_op", 32'(add_op), 1);
    tick(); check("inc1", 32'(pc), 32'h001001);
    tick(); check("inc2", 32'(pc), 32'h001002);
    tick(); check("inc3", 32'(pc), 32'h001003);
    bus.cmd_valid = 1'b0;
    tick(); check("inc_hold", 32'(pc), 32'h001003);

    // Branch across a page
    bus.jump_addr = 24'h0010F0;
    issue(3'd3);
    bus.disp      = 24'h000020;
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd2;
    #1;
    check("br_op", 32'(add_op), 2);
    check("br_disp", 32'(add_disp), 32'h20);
    tick();
    bus.cmd_valid = 1'b0;
    check("br_pc", 32'(pc), 32'h001110);
`ifdef PCS_PAGE_CROSS_EN
    check("br_pcross", 32'(page_cross), 1);
    check("br_penalty_ready", 32'(bus.cmd_ready), 0);
    tick();
    check("br_pcross_clr", 32'(page_cross), 0);
    check("br_after_ready", 32'(bus.cmd_ready), 1);
`else
    check("br_pcross", 32'(page_cross), 0);
    check("br_ready", 32'(bus.cmd_ready), 1);
`endif

    // Backward branch within the page
    bus.disp = 24'hFFFFF0;
    issue(3'd2);
    check("br_back_pc", 32'(pc), 32'h001100);
    check("br_back_pcross", 32'(page_cross), 0);
    tick();

    // Block move of 3 bytes
    bus.jump_addr = 24'h002003;
    issue(3'd3);
    bus.bm_count = 16'd2;
    issue(3'd4);
    check("bm_busy", 32'(bm_busy), 1);
    check("bm_pc_held", 32'(pc), 32'h002003);
    check("bm_ready", 32'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd1;
    #1;
    check("bm_idle_op", 32'(add_op), 0);
    tick(); tick();
    bus.cmd_valid = 1'b0;
    check("bm_no_accept", 32'(pc), 32'h002003);
    mv_done = 1'b1;
    #1;
    check("bm_rewind_op", 32'(add_op), 3);
    tick();
    mv_done = 1'b0;
    check("bm_mv1", 32'(pc), 32'h002000);
    tick();
    check("bm_gap", 32'(pc), 32'h002000);
    mv_done = 1'b1;
    tick();
    mv_done = 1'b0;
    check("bm_mv2", 32'(pc), 32'h001FFD);
    check("bm_mv2_done", 32'(bm_done), 0);
    mv_done = 1'b1;
    #1;
    check("bm_last_op", 32'(add_op), 0);
    tick();
    mv_done = 1'b0;
    check("bm_mv3", 32'(pc), 32'h001FFD);
    check("bm_done", 32'(bm_done), 1);
    check("bm_busy_clr", 32'(bm_busy), 0);
    tick();
    check("bm_done_pulse", 32'(bm_done), 0);

    // Wrap-around
    bus.jump_addr = 24'hFFFFFF;
    issue(3'd3);
    issue(3'd1);
    check("wrap_inc", 32'(pc), 32'h000000);
    bus.jump_addr = 24'h000001;
    issue(3'd3);
    bus.bm_count = 16'd1;
    issue(3'd4);
    mv_done = 1'b1;
    tick();
    mv_done = 1'b0;
    check("wrap_rewind", 32'(pc), 32'hFFFFFE);
    check("wrap_busy", 32'(bm_busy), 1);

    // Reset aborts block move
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_pc", 32'(pc), 32'h00FFFC);
    check("abort_busy", 32'(bm_busy), 0);
    check("abort_done", 32'(bm_done), 0);

    // mv_done in IDLE ignored
    mv_done = 1'b1;
    tick();
    mv_done = 1'b0;
    check("mv_idle_pc", 32'(pc), 32'h00FFFC);
    check("mv_idle_done", 32'(bm_done), 0);

    // rdy low freezes
    rdy           = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd1;
    #1;
    check("frz_ready", 32'(bus.cmd_ready), 0);
    check("frz_op", 32'(add_op), 0);
    repeat (4) tick();
    check("frz_pc", 32'(pc), 32'h00FFFC);
    rdy = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("unfrz_pc", 32'(pc), 32'h00FFFD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
